// File: rtl/nx_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : nx_fifo_wr_arb
// Brief    : Round-robin multi-requester write arbiter for a credit-tracked
//            FIFO, with a drain/clear/wait flush sequence and overflow flag.
//            Optional macro NX_FIFO_WR_ARB_STATS_EN adds per-requester
//            saturating transfer counters on stat_grant_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module nx_fifo_wr_arb #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 71,
    parameter int DEPTH = 2048,
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_wen,
    output logic [WIDTH-1:0]       fifo_wdata,
    input  logic [CW-1:0]          fifo_free_slots,
    input  logic [CW-1:0]          fifo_used_slots,
    output logic                   fifo_clear,
    input  logic                   clear_req,
    output logic                   clear_done,
    output logic [GW-1:0]          grant_id,
    output logic                   ovf_err
`ifdef NX_FIFO_WR_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]    stat_grant_cnt
`endif
);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_CLEAR = 2'd2;
    localparam logic [1:0] c_ST_WAIT  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [GW-1:0]    r_ptr;
    logic [GW-1:0]    r_grant_id;
    logic [GW-1:0]    w_sel;
    logic [GW-1:0]    w_ptr_nxt;
    logic             w_found;
    logic             w_credit;
    logic             w_grant_en;
    logic             w_xfer;
    logic             w_done;
    logic             r_fifo_wen;
    logic [WIDTH-1:0] r_fifo_wdata;
    logic             r_clear_done;
    logic             r_ovf_err;

    // First valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_sel   = GW'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    // The write already in flight consumes one slot not yet reflected in the count.
    assign w_credit   = fifo_free_slots > CW'(r_fifo_wen);
    assign w_grant_en = !rst && (r_state == c_ST_RUN) && !clear_req && w_credit;
    assign w_xfer     = w_grant_en && w_found;
    assign w_ptr_nxt  = (w_sel == GW'(N_REQ - 1)) ? '0 : w_sel + 1'b1;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_xfer && (w_sel == GW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            c_ST_RUN:   if (clear_req) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (!r_fifo_wen) w_state_nxt = c_ST_CLEAR;
            c_ST_CLEAR: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: begin
                if (fifo_used_slots == '0) begin
                    w_done = 1'b1;
                    if (!clear_req) w_state_nxt = c_ST_RUN;
                end
            end
            default:    w_state_nxt = c_ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_grant_id   <= '0;
            r_fifo_wen   <= 1'b0;
            r_fifo_wdata <= '0;
            r_clear_done <= 1'b0;
            r_ovf_err    <= 1'b0;
        end else begin
            r_fifo_wen   <= w_xfer;
            r_clear_done <= w_done;
            if (w_xfer) begin
                r_fifo_wdata <= req_data[int'(w_sel)*WIDTH +: WIDTH];
                r_ptr        <= w_ptr_nxt;
                r_grant_id   <= w_sel;
            end
            if (r_fifo_wen && (fifo_free_slots == '0)) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign fifo_wen   = r_fifo_wen;
    assign fifo_wdata = r_fifo_wdata;
    assign fifo_clear = (r_state == c_ST_CLEAR);
    assign clear_done = r_clear_done;
    assign grant_id   = r_grant_id;
    assign ovf_err    = r_ovf_err;

`ifdef NX_FIFO_WR_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
            logic [15:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst || (r_state == c_ST_CLEAR)) begin
                    r_cnt <= '0;
                end else if (req_valid[gi] && req_ready[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign stat_grant_cnt[gi*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire
